// File: rtl/mac_cfg_loader.sv
// mac_cfg_loader: serial configuration loader for a row of MAC blocks.
//
// A bit-serial stream (LSB first, block 0 first) is assembled into one
// {init_val, conf} word per block in shadow registers. Once every block's word
// has arrived, the whole set is committed to cfg_out in a single cycle. If any
// word carried the illegal mode 2'b11, cfg_out is left untouched. mac_en is
// held low whenever a load or commit is in progress.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-low reset
//   cfg_start  - pulse: begin or restart a load
//   cfg_bit    - serial config data
//   cfg_valid  - cfg_bit qualifier
//   cfg_ready  - loader is accepting bits (LOAD state)
//   en_in      - fabric enable request
//   cfg_out    - committed config, block i at [(i+1)*W-1 : i*W]
//   mac_en     - enable to all MAC blocks
//   cfg_done   - one-cycle pulse after a successful commit
//   cfg_err    - sticky illegal-mode flag for the current/last load
//   loaded     - a valid config has been committed since reset

`ifndef MAC_ACC_WIDTH
`define MAC_ACC_WIDTH 32
`endif
`ifndef MAC_CONF_WIDTH
`define MAC_CONF_WIDTH 3
`endif

module mac_cfg_loader #(
  parameter int unsigned ACC_WIDTH  = `MAC_ACC_WIDTH,
  parameter int unsigned CONF_WIDTH = `MAC_CONF_WIDTH,
  parameter int unsigned NUM_BLOCKS = 4
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          cfg_start,
  input  logic                                          cfg_bit,
  input  logic                                          cfg_valid,
  output logic                                          cfg_ready,
  input  logic                                          en_in,
  output logic [NUM_BLOCKS*(ACC_WIDTH+CONF_WIDTH)-1:0]  cfg_out,
  output logic                                          mac_en,
  output logic                                          cfg_done,
  output logic                                          cfg_err,
  output logic                                          loaded
);

  localparam int unsigned W    = ACC_WIDTH + CONF_WIDTH;
  localparam int unsigned TotW = NUM_BLOCKS * W;
  localparam int unsigned CntW = $clog2(W + 1);
  localparam int unsigned IdxW = $clog2(NUM_BLOCKS + 1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StLoad   = 2'd1;
  localparam logic [1:0] StCommit = 2'd2;

  localparam logic [CntW-1:0] CntLast = CntW'(W - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_BLOCKS - 1);

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [W-2:0]    asm_q, asm_d;
  logic [TotW-1:0] shadow_q, shadow_d;
  logic [TotW-1:0] cfg_out_q, cfg_out_d;
  logic            err_q, err_d;
  logic            loaded_q, loaded_d;
  logic            done_q, done_d;
  logic [W-1:0]    word;

  // Bits shift in from the top, so after W bits the first one sits at bit 0.
  // The assembly register holds only the W-1 bits preceding the current one.
  assign word = {cfg_bit, asm_q};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    asm_d     = asm_q;
    shadow_d  = shadow_q;
    cfg_out_d = cfg_out_q;
    err_d     = err_q;
    loaded_d  = loaded_q;
    done_d    = 1'b0;

    case (state_q)
      StIdle: begin
        if (cfg_start) begin
          state_d  = StLoad;
          cnt_d    = '0;
          idx_d    = '0;
          err_d    = 1'b0;
          shadow_d = '0;
        end
      end
      StLoad: begin
        if (cfg_start) begin
          // Restart: the bit presented alongside the start is dropped.
          cnt_d    = '0;
          idx_d    = '0;
          err_d    = 1'b0;
          shadow_d = '0;
        end else if (cfg_valid) begin
          asm_d = word[W-1:1];
          if (cnt_q == CntLast) begin
            cnt_d = '0;
            for (int i = 0; i < NUM_BLOCKS; i++) begin
              if (idx_q == IdxW'(i)) begin
                shadow_d[i*W +: W] = word;
              end
            end
            if (word[1:0] == 2'b11) begin
              err_d = 1'b1;
            end
            if (idx_q == IdxLast) begin
              state_d = StCommit;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StCommit: begin
        if (!err_q) begin
          cfg_out_d = shadow_q;
          loaded_d  = 1'b1;
          done_d    = 1'b1;
        end
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      idx_q     <= '0;
      asm_q     <= '0;
      shadow_q  <= '0;
      cfg_out_q <= '0;
      err_q     <= 1'b0;
      loaded_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      asm_q     <= asm_d;
      shadow_q  <= shadow_d;
      cfg_out_q <= cfg_out_d;
      err_q     <= err_d;
      loaded_q  <= loaded_d;
      done_q    <= done_d;
    end
  end

  assign cfg_ready = (state_q == StLoad);
  assign mac_en    = en_in && (state_q == StIdle) && loaded_q;
  assign cfg_out   = cfg_out_q;
  assign cfg_done  = done_q;
  assign cfg_err   = err_q;
  assign loaded    = loaded_q;

endmodule

// File: tb/tb_mac_cfg_loader.sv
// tb_mac_cfg_loader: directed bench for mac_cfg_loader (2 blocks, 32+3 bits).
// A stream-level model (accepted bits collected by position) is compared with
// the DUT on every falling edge; literal expectations pin key cycles.

module tb_mac_cfg_loader;

  localparam int NB  = 2;
  localparam int W   = 35;
  localparam int TOT = NB * W;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           cfg_start = 1'b0;
  logic           cfg_bit = 1'b0;
  logic           cfg_valid = 1'b0;
  logic           en_in = 1'b1;
  logic           cfg_ready;
  logic [TOT-1:0] cfg_out;
  logic           mac_en;
  logic           cfg_done;
  logic           cfg_err;
  logic           loaded;

  int n_checks = 0;
  int n_fail   = 0;
  int done_seen = 0;

  mac_cfg_loader #(
    .ACC_WIDTH (32),
    .CONF_WIDTH(3),
    .NUM_BLOCKS(NB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_start(cfg_start),
    .cfg_bit  (cfg_bit),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .en_in    (en_in),
    .cfg_out  (cfg_out),
    .mac_en   (mac_en),
    .cfg_done (cfg_done),
    .cfg_err  (cfg_err),
    .loaded   (loaded)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [TOT-1:0] act,
                       input logic [TOT-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_phase: 0 waiting for start, 1 collecting bits, 2 one commit cycle.
  int             m_phase = 0;
  int             m_cnt = 0;
  logic [TOT-1:0] m_stream = '0;
  logic [TOT-1:0] m_cfg = '0;
  bit             m_err = 0;
  bit             m_loaded = 0;
  bit             m_done = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase  = 0;
      m_cnt    = 0;
      m_stream = '0;
      m_cfg    = '0;
      m_err    = 0;
      m_loaded = 0;
      m_done   = 0;
    end else begin
      m_done = 0;
      if (m_phase == 2) begin
        if (!m_err) begin
          m_cfg    = m_stream;
          m_loaded = 1;
          m_done   = 1;
        end
        m_phase = 0;
      end else if (cfg_start) begin
        m_phase = 1;
        m_cnt   = 0;
        m_err   = 0;
      end else if (m_phase == 1 && cfg_valid) begin
        m_stream[m_cnt] = cfg_bit;
        m_cnt++;
        if (m_cnt % W == 0) begin
          if (m_stream[m_cnt-W +: 2] == 2'b11) m_err = 1;
          if (m_cnt == TOT) m_phase = 2;
        end
      end
    end
  end

  // Compare process: every falling edge, DUT against model.
  initial begin : monitor
    forever begin
      @(negedge clk);
      check("m_cfg_out", cfg_out, m_cfg);
      check("m_cfg_ready", TOT'(cfg_ready), TOT'(m_phase == 1));
      check("m_cfg_done", TOT'(cfg_done), TOT'(m_done));
      check("m_cfg_err", TOT'(cfg_err), TOT'(m_err));
      check("m_loaded", TOT'(loaded), TOT'(m_loaded));
      check("m_mac_en", TOT'(mac_en), TOT'(en_in && m_phase == 0 && m_loaded));
      if (cfg_done === 1'b1) done_seen++;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic send_bits(input logic [TOT-1:0] data, input int nbits, input bit gapped);
    for (int i = 0; i < nbits; i++) begin
      if (gapped) begin
        cfg_valid = 1'b0;
        cfg_bit   = ~data[i];
        tick();
      end
      cfg_valid = 1'b1;
      cfg_bit   = data[i];
      tick();
    end
    cfg_valid = 1'b0;
    cfg_bit   = 1'b0;
  endtask

  // After the last bit's edge: COMMIT cycle, then the done cycle.
  task automatic check_commit(input string tag, input logic [TOT-1:0] exp_out,
                              input bit exp_ok, input logic [TOT-1:0] prev_out);
    check({tag, "_ready_in_commit"}, TOT'(cfg_ready), '0);
    check({tag, "_mac_en_in_commit"}, TOT'(mac_en), '0);
    check({tag, "_out_in_commit"}, cfg_out, prev_out);
    tick();
    check({tag, "_done"}, TOT'(cfg_done), TOT'(exp_ok));
    check({tag, "_out"}, cfg_out, exp_out);
    check({tag, "_loaded"}, TOT'(loaded), TOT'(1));
    check({tag, "_err"}, TOT'(cfg_err), TOT'(!exp_ok));
    check({tag, "_mac_en"}, TOT'(mac_en), TOT'(1));
    tick();
    check({tag, "_done_cleared"}, TOT'(cfg_done), '0);
  endtask

  logic [TOT-1:0] d1, d2, d3, junk;
  int             done_before;

  initial begin : stim
    d1   = 70'h8_0000_0084;                    // {35'h1, 35'h84}
    d2   = {35'h3, 35'h84};                    // block1 mode 2'b11
    d3   = {35'h0_91A2_B3C5, 35'h6_F56D_F77A}; // {1234_5678,101},{DEAD_BEEF,010}
    junk = {35'h7_FFFF_FFFF, 35'h5_5555_5555};

    #1 rst = 1'b0;
    #20;
    check("rst_cfg_out", cfg_out, '0);
    check("rst_ready", TOT'(cfg_ready), '0);
    check("rst_loaded", TOT'(loaded), '0);
    check("rst_mac_en", TOT'(mac_en), '0);
    check("rst_done", TOT'(cfg_done), '0);
    check("rst_err", TOT'(cfg_err), '0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("idle_ready", TOT'(cfg_ready), '0);

    // Normal load.
    pulse_start();
    check("norm_ready_after_start", TOT'(cfg_ready), TOT'(1));
    check("norm_mac_en_loading", TOT'(mac_en), '0);
    send_bits(d1, TOT, 1'b0);
    check_commit("norm", d1, 1'b1, '0);

    // Gapped valid; mac_en drops the cycle after start.
    pulse_start();
    check("gap_mac_en_after_start", TOT'(mac_en), '0);
    send_bits(d1, TOT, 1'b1);
    check_commit("gap", d1, 1'b1, d1);

    // Illegal mode in block1: no commit, error sticks.
    pulse_start();
    send_bits(d2, TOT, 1'b0);
    check_commit("ill", d1, 1'b0, d1);
    tick();
    check("ill_err_sticky", TOT'(cfg_err), TOT'(1));

    // Restart after 20 bits; start clears the error.
    done_before = done_seen;
    pulse_start();
    check("rst_seq_err_cleared", TOT'(cfg_err), '0);
    send_bits(junk, 20, 1'b0);
    cfg_start = 1'b1;
    cfg_valid = 1'b1;
    cfg_bit   = 1'b1;
    tick();
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    check("restart_ready", TOT'(cfg_ready), TOT'(1));
    send_bits(d3, TOT, 1'b0);
    check_commit("restart", d3, 1'b1, d1);
    check("restart_done_once", TOT'(done_seen - done_before), TOT'(1));

    // Reset asserted mid-load after 40 bits.
    pulse_start();
    send_bits(d1, 40, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_cfg_out", cfg_out, '0);
    check("mid_rst_loaded", TOT'(loaded), '0);
    check("mid_rst_ready", TOT'(cfg_ready), '0);
    check("mid_rst_mac_en", TOT'(mac_en), '0);
    check("mid_rst_err", TOT'(cfg_err), '0);
    check("mid_rst_done", TOT'(cfg_done), '0);
    @(negedge clk);
    rst = 1'b1;
    send_bits(d3, 10, 1'b0);
    check("post_rst_ready", TOT'(cfg_ready), '0);
    check("post_rst_cfg_out", cfg_out, '0);
    check("post_rst_loaded", TOT'(loaded), '0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
